branch_predictor: RTL

//   Parametrised dynamic branch predictor for the pipelined RV64 core. Sits beside the program counter in IF.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_counter_table.sv | 32 +++
 rtl/branch_predictor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings, mode
// constants and the saturating counter step.
package bp_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   localparam int PRED_BIMODAL = 0;
   localparam int PRED_GSHARE  = 1;

   function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && (ctr != CTR_ST)) begin
         nxt = ctr + 2'd1;
      end else if (!taken && (ctr != CTR_SNT)) begin
         nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_counter_table.sv
// ENTRIES x 2-bit saturating counter table: async read, sync update,
// sync reset to weakly not-taken.
module bp_counter_table
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int IDX_BITS = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [1:0]          rd_ctr,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);

   logic [1:0] ctr [ENTRIES];

   assign rd_ctr = ctr[rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= CTR_WNT;
         end
      end else if (wr_en) begin
         ctr[wr_idx] <= sat2_next(ctr[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged BTB plus 2-bit counters, bimodal or gshare
// indexed, trained from decode-stage resolution, with saturating perf counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int ENTRIES   = 64,
   parameter int TAG_BITS  = 12,
   parameter int PRED_MODE = 0,
   parameter int HIST_BITS = 6,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  lookup_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   output logic             pred_hit,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_is_branch,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   input  logic             upd_pred_taken,
   input  logic [XLEN-1:0]  upd_pred_target,
   output logic             mispredict,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispred
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_LO   = IDX_BITS + 2;
   localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;

   logic                btb_valid  [ENTRIES];
   logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
   logic [XLEN-1:0]     btb_target [ENTRIES];
   logic                btb_jump   [ENTRIES];

   logic [HIST_BITS-1:0] ghr;
   logic [HIST_BITS:0]   ghr_shift;
   logic [IDX_BITS-1:0]  ghr_ext;
   logic [IDX_BITS-1:0]  lk_idx, lk_cidx, up_idx, up_cidx;
   logic [TAG_BITS-1:0]  lk_tag, up_tag;
   logic [1:0]           lk_ctr;
   logic                 lk_hit;
   logic                 unused_bits;

   assign lk_idx = lookup_pc[IDX_BITS+1:2];
   assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
   assign up_idx = upd_pc[IDX_BITS+1:2];
   assign up_tag = upd_pc[TAG_HI:TAG_LO];

   always_comb begin
      ghr_ext = '0;
      ghr_ext[HIST_BITS-1:0] = ghr;
   end

   // Both ports hash with the current (pre-shift) history.
   assign lk_cidx = (PRED_MODE == PRED_GSHARE) ? (lk_idx ^ ghr_ext) : lk_idx;
   assign up_cidx = (PRED_MODE == PRED_GSHARE) ? (up_idx ^ ghr_ext) : up_idx;
   assign ghr_shift = {ghr, upd_taken};

   bp_counter_table #(
      .ENTRIES  (ENTRIES),
      .IDX_BITS (IDX_BITS)
   ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (lk_cidx),
      .rd_ctr   (lk_ctr),
      .wr_en    (upd_valid && upd_is_branch),
      .wr_idx   (up_cidx),
      .wr_taken (upd_taken)
   );

   assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
   assign pred_hit    = lk_hit;
   assign pred_taken  = lk_hit && (btb_jump[lk_idx] || lk_ctr[1]);
   assign pred_target = pred_taken ? btb_target[lk_idx] : '0;

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
         end
      end else if (upd_valid && upd_taken) begin
         btb_valid[up_idx] <= 1'b1;
      end
   end

   // Payload needs no reset: it is only ever observed through a valid entry.
   always_ff @(posedge clk) begin
      if (!reset && upd_valid && upd_taken) begin
         btb_tag[up_idx]    <= up_tag;
         btb_target[up_idx] <= upd_target;
         btb_jump[up_idx]   <= !upd_is_branch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ghr           <= '0;
         perf_branches <= '0;
         perf_mispred  <= '0;
      end else if (upd_valid) begin
         if (upd_is_branch && (PRED_MODE == PRED_GSHARE)) begin
            ghr <= ghr_shift[HIST_BITS-1:0];
         end
         if (perf_branches != '1) begin
            perf_branches <= perf_branches + CNT_W'(1);
         end
         if (mispredict && (perf_mispred != '1)) begin
            perf_mispred <= perf_mispred + CNT_W'(1);
         end
      end
   end

   assign unused_bits = ^{lookup_pc[XLEN-1:TAG_HI+1], lookup_pc[1:0],
                          upd_pc[XLEN-1:TAG_HI+1], upd_pc[1:0],
                          ghr_shift[HIST_BITS], lk_ctr[0]};

endmodule
